// File: rtl/mem_arbiter.sv
// Two-master memory bus arbiter: instruction fetch (master 0) vs load/store (master 1).
// Data wins ties; a starvation counter forces a pending fetch through after STARVE_LIMIT data grants.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_addr,
    input  logic        if_valid,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic [31:0] ls_addr,
    input  logic [3:0]  ls_lanes,
    input  logic [31:0] ls_wdata,
    input  logic        ls_wr,
    input  logic        ls_valid,
    output logic        ls_ready,
    output logic [31:0] ls_rdata,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_lanes,
    output logic [31:0] bus_dout,
    output logic        bus_wr,
    output logic        bus_valid,
    input  logic        bus_ready,
    input  logic [31:0] bus_din,
    output logic [1:0]  gnt
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [7:0]  starve_q, starve_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_lanes_q, bus_lanes_d;
    logic [31:0] bus_dout_q, bus_dout_d;
    logic        bus_wr_q, bus_wr_d;
    logic        bus_valid_q, bus_valid_d;
    logic        if_ready_q, if_ready_d;
    logic        ls_ready_q, ls_ready_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        pick_ls;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        bus_addr_d  = bus_addr_q;
        bus_lanes_d = bus_lanes_q;
        bus_dout_d  = bus_dout_q;
        bus_wr_d    = bus_wr_q;
        bus_valid_d = bus_valid_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        gnt_d       = gnt_q;
        if_ready_d  = 1'b0;
        ls_ready_d  = 1'b0;
        pick_ls     = ls_valid && !(if_valid && (starve_q >= LIMIT));

        unique case (state_q)
            IDLE: begin
                if (if_valid || ls_valid) begin
                    state_d     = BUSY;
                    bus_valid_d = 1'b1;
                    if (pick_ls) begin
                        bus_addr_d  = ls_addr;
                        bus_lanes_d = ls_lanes;
                        bus_dout_d  = ls_wdata;
                        bus_wr_d    = ls_wr;
                        gnt_d       = 2'b10;
                        // Only count data grants that actually made a fetch wait.
                        if (if_valid && (starve_q != 8'hff)) begin
                            starve_d = starve_q + 8'd1;
                        end
                    end else begin
                        bus_addr_d  = if_addr;
                        bus_lanes_d = 4'b1111;
                        bus_dout_d  = 32'h0;
                        bus_wr_d    = 1'b0;
                        gnt_d       = 2'b01;
                        starve_d    = 8'h00;
                    end
                end
            end
            BUSY: begin
                if (bus_ready) begin
                    state_d     = DONE;
                    bus_valid_d = 1'b0;
                    if (gnt_q[1]) begin
                        ls_rdata_d = bus_din;
                        ls_ready_d = 1'b1;
                    end else begin
                        if_rdata_d = bus_din;
                        if_ready_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= 8'h00;
            bus_addr_q  <= 32'h0;
            bus_lanes_q <= 4'h0;
            bus_dout_q  <= 32'h0;
            bus_wr_q    <= 1'b0;
            bus_valid_q <= 1'b0;
            if_ready_q  <= 1'b0;
            ls_ready_q  <= 1'b0;
            if_rdata_q  <= 32'h0;
            ls_rdata_q  <= 32'h0;
            gnt_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            bus_addr_q  <= bus_addr_d;
            bus_lanes_q <= bus_lanes_d;
            bus_dout_q  <= bus_dout_d;
            bus_wr_q    <= bus_wr_d;
            bus_valid_q <= bus_valid_d;
            if_ready_q  <= if_ready_d;
            ls_ready_q  <= ls_ready_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            gnt_q       <= gnt_d;
        end
    end

    assign bus_addr  = bus_addr_q;
    assign bus_lanes = bus_lanes_q;
    assign bus_dout  = bus_dout_q;
    assign bus_wr    = bus_wr_q;
    assign bus_valid = bus_valid_q;
    assign if_ready  = if_ready_q;
    assign ls_ready  = ls_ready_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign gnt       = gnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner sequences,
// then random traffic against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int LIM = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_addr;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic [31:0] ls_addr;
    logic [3:0]  ls_lanes;
    logic [31:0] ls_wdata;
    logic        ls_wr;
    logic        ls_valid;
    logic        ls_ready;
    logic [31:0] ls_rdata;
    logic [31:0] bus_addr;
    logic [3:0]  bus_lanes;
    logic [31:0] bus_dout;
    logic        bus_wr;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_din;
    logic [1:0]  gnt;

    mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_addr  (if_addr),
        .if_valid (if_valid),
        .if_ready (if_ready),
        .if_rdata (if_rdata),
        .ls_addr  (ls_addr),
        .ls_lanes (ls_lanes),
        .ls_wdata (ls_wdata),
        .ls_wr    (ls_wr),
        .ls_valid (ls_valid),
        .ls_ready (ls_ready),
        .ls_rdata (ls_rdata),
        .bus_addr (bus_addr),
        .bus_lanes(bus_lanes),
        .bus_dout (bus_dout),
        .bus_wr   (bus_wr),
        .bus_valid(bus_valid),
        .bus_ready(bus_ready),
        .bus_din  (bus_din),
        .gnt      (gnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_data;
        logic [31:0] addr;
        logic [3:0]  lanes;
        logic [31:0] wdata;
        logic        wr;
        int          waits;
        logic [31:0] din;
        logic [1:0]  e_gnt;
        logic [3:0]  e_lanes;
        logic        e_wr;
        logic [31:0] e_dout;
    } vec_t;

    vec_t        vecs[5];
    int          n_pass = 0;
    int          n_tot  = 0;
    logic [31:0] e_if_rd, e_ls_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_rd();
        chk("if_rdata", if_rdata, e_if_rd);
        chk("ls_rdata", ls_rdata, e_ls_rd);
    endtask

    task automatic run_single(input vec_t v);
        if_valid  = !v.is_data;
        ls_valid  = v.is_data;
        if_addr   = v.addr;
        ls_addr   = v.addr;
        ls_lanes  = v.lanes;
        ls_wdata  = v.wdata;
        ls_wr     = v.wr;
        bus_ready = 1'b0;
        step();
        chk("v_gnt", gnt, v.e_gnt);
        chk("v_bus_valid", bus_valid, 1);
        chk("v_bus_addr", bus_addr, v.addr);
        chk("v_bus_lanes", bus_lanes, v.e_lanes);
        chk("v_bus_wr", bus_wr, v.e_wr);
        chk("v_bus_dout", bus_dout, v.e_dout);
        for (int w = 0; w < v.waits; w++) begin
            step();
            chk("v_hold_valid", bus_valid, 1);
            chk("v_hold_addr", bus_addr, v.addr);
            chk("v_hold_lanes", bus_lanes, v.e_lanes);
            chk("v_hold_dout", bus_dout, v.e_dout);
            chk("v_hold_rdy", {if_ready, ls_ready}, 0);
        end
        bus_ready = 1'b1;
        bus_din   = v.din;
        step();
        if (v.is_data) e_ls_rd = v.din;
        else e_if_rd = v.din;
        chk("v_if_ready", if_ready, !v.is_data);
        chk("v_ls_ready", ls_ready, v.is_data);
        chk("v_done_gnt", gnt, v.e_gnt);
        chk("v_done_valid", bus_valid, 0);
        chk_rd();
        if_valid  = 1'b0;
        ls_valid  = 1'b0;
        bus_ready = 1'b0;
        step();
        chk("v_idle_gnt", gnt, 0);
        chk("v_idle_rdy", {if_ready, ls_ready}, 0);
    endtask

    // Reference model state for the random phase
    int          m_phase;
    logic        m_data;
    logic [7:0]  m_starve;
    logic [31:0] m_addr, m_dout;
    logic [3:0]  m_lanes;
    logic        m_wr;

    initial begin
        vecs[0] = '{1'b0, 32'h0000_0100, 4'b0101, 32'h1111_2222, 1'b1, 0, 32'h0000_0013,
                    2'b01, 4'b1111, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 32'h0000_2002, 4'b1100, 32'hBEEF_0000, 1'b1, 3, 32'h1234_5678,
                    2'b10, 4'b1100, 1'b1, 32'hBEEF_0000};
        vecs[2] = '{1'b1, 32'h0000_4000, 4'b1111, 32'h0BAD_0BAD, 1'b0, 1, 32'hCAFE_F00D,
                    2'b10, 4'b1111, 1'b0, 32'h0BAD_0BAD};
        vecs[3] = '{1'b0, 32'hFFFF_FFFC, 4'b0000, 32'h7777_7777, 1'b1, 2, 32'hDEAD_BEEF,
                    2'b01, 4'b1111, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 32'h0000_0003, 4'b0001, 32'h0000_00A5, 1'b1, 0, 32'h0000_005A,
                    2'b10, 4'b0001, 1'b1, 32'h0000_00A5};

        rst = 1'b1;
        if_addr = 0; if_valid = 0; ls_addr = 0; ls_lanes = 0;
        ls_wdata = 0; ls_wr = 0; ls_valid = 0; bus_ready = 0; bus_din = 0;
        e_if_rd = 0; e_ls_rd = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out", {bus_valid, bus_wr, if_ready, ls_ready, gnt, bus_lanes}, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_dout", bus_dout, 0);
        chk("rst_starve", dut.starve_q, 0);
        chk_rd();
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) run_single(vecs[i]);

        // Both request together: data first, then fetch
        if_valid = 1; if_addr = 32'h200;
        ls_valid = 1; ls_addr = 32'h300; ls_lanes = 4'hF; ls_wr = 0;
        step();
        chk("both_gnt1", gnt, 2'b10);
        chk("both_addr1", bus_addr, 32'h300);
        chk("both_starve1", dut.starve_q, 1);
        bus_ready = 1; bus_din = 32'hAAAA_0001;
        step();
        e_ls_rd = 32'hAAAA_0001;
        chk("both_ls_ready", ls_ready, 1);
        chk("both_if_ready", if_ready, 0);
        chk_rd();
        ls_valid = 0; bus_ready = 0;
        step();
        chk("both_idle", gnt, 0);
        step();
        chk("both_gnt2", gnt, 2'b01);
        chk("both_addr2", bus_addr, 32'h200);
        chk("both_starve2", dut.starve_q, 0);
        bus_ready = 1; bus_din = 32'hBBBB_0002;
        step();
        e_if_rd = 32'hBBBB_0002;
        chk("both_if_ready2", if_ready, 1);
        chk_rd();
        bus_ready = 0;
        step();

        // Starvation: fetch held, data re-requested every idle
        for (int i = 0; i < 6; i++) begin
            logic d;
            d = (i % 3) != 2;
            if_valid = 1; if_addr = 32'h500 + i;
            ls_valid = 1; ls_addr = 32'h600 + i;
            step();
            chk("starve_gnt", gnt, d ? 2'b10 : 2'b01);
            chk("starve_addr", bus_addr, d ? 32'h600 + i : 32'h500 + i);
            bus_ready = 1; bus_din = 32'h1000 + i;
            step();
            if (d) e_ls_rd = 32'h1000 + i;
            else e_if_rd = 32'h1000 + i;
            chk_rd();
            ls_valid = 0; bus_ready = 0;
            step();
        end
        if_valid = 0;

        // Reset during BUSY abandons the access
        ls_valid = 1; ls_addr = 32'h55; ls_wr = 1; ls_lanes = 4'b0011; ls_wdata = 32'h1234;
        step();
        chk("rb_gnt", gnt, 2'b10);
        step();
        rst = 1; ls_valid = 0;
        #1;
        chk("rb_out", {bus_valid, if_ready, ls_ready, gnt}, 0);
        chk("rb_addr", bus_addr, 0);
        e_if_rd = 0; e_ls_rd = 0;
        chk_rd();
        bus_ready = 1; bus_din = 32'hFFFF_FFFF;
        @(negedge clk);
        rst = 0;
        step();
        chk("rb_no_ready", {if_ready, ls_ready, bus_valid, gnt}, 0);
        chk_rd();
        bus_ready = 0;
        run_single(vecs[0]);

        // Spurious bus_ready while idle
        bus_ready = 1; bus_din = 32'h0F0F_0F0F;
        step();
        step();
        chk("spur_out", {if_ready, ls_ready, bus_valid, gnt}, 0);
        chk_rd();
        bus_ready = 0;
        step();

        // Random traffic against the transaction-level model
        begin
            int  wcnt, if_wait, ls_wait, max_wait;
            bit  armed;
            m_phase = 0; m_starve = 0; m_data = 0;
            m_addr = 0; m_dout = 0; m_lanes = 0; m_wr = 0;
            wcnt = 0; armed = 0; if_wait = 0; ls_wait = 0; max_wait = 0;
            for (int cyc = 0; cyc < 1500; cyc++) begin
                if (if_valid && if_ready) if_valid = 0;
                else if (!if_valid && ($urandom % 3 == 0)) begin
                    if_valid = 1; if_addr = $urandom;
                end
                if (ls_valid && ls_ready) ls_valid = 0;
                else if (!ls_valid && ($urandom % 3 == 0)) begin
                    ls_valid = 1; ls_addr = $urandom; ls_wdata = $urandom;
                    ls_lanes = 4'($urandom); ls_wr = 1'($urandom);
                end
                if (bus_valid) begin
                    if (!armed) begin wcnt = $urandom % 4; armed = 1; end
                    if (wcnt == 0) begin bus_ready = 1; bus_din = $urandom; end
                    else begin wcnt--; bus_ready = 0; end
                end else begin
                    armed = 0;
                    bus_ready = ($urandom % 4 == 0);
                    bus_din = $urandom;
                end
                if_wait = if_valid ? if_wait + 1 : 0;
                ls_wait = ls_valid ? ls_wait + 1 : 0;
                if (if_wait > max_wait) max_wait = if_wait;
                if (ls_wait > max_wait) max_wait = ls_wait;

                @(posedge clk);
                if (m_phase == 0) begin
                    if (if_valid || ls_valid) begin
                        m_data = ls_valid && !(if_valid && m_starve >= LIM);
                        m_addr  = m_data ? ls_addr : if_addr;
                        m_lanes = m_data ? ls_lanes : 4'hF;
                        m_dout  = m_data ? ls_wdata : 32'h0;
                        m_wr    = m_data ? ls_wr : 1'b0;
                        if (!m_data) m_starve = 0;
                        else if (if_valid && m_starve < 255) m_starve++;
                        m_phase = 1;
                    end
                end else if (m_phase == 1) begin
                    if (bus_ready) begin
                        if (m_data) e_ls_rd = bus_din;
                        else e_if_rd = bus_din;
                        m_phase = 2;
                    end
                end else m_phase = 0;
                @(negedge clk);

                chk("r_gnt", gnt, m_phase == 0 ? 2'b00 : (m_data ? 2'b10 : 2'b01));
                chk("r_valid", bus_valid, m_phase == 1);
                chk("r_if_ready", if_ready, m_phase == 2 && !m_data);
                chk("r_ls_ready", ls_ready, m_phase == 2 && m_data);
                chk("r_starve", dut.starve_q, m_starve);
                chk_rd();
                if (m_phase == 1) begin
                    chk("r_addr", bus_addr, m_addr);
                    chk("r_lanes", bus_lanes, m_lanes);
                    chk("r_dout", bus_dout, m_dout);
                    chk("r_wr", bus_wr, m_wr);
                end
            end
            chk("r_wait_bound", max_wait <= 100, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
